// File: rtl/traffic_ctrl_multi.sv
// Multi-phase traffic-light controller: tick timer, demand-driven
// round-robin phase selection, all-red clearance and flash mode.
module traffic_ctrl_multi #(
  parameter int PHASES   = 2,
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 25,
  parameter int YELLOW_T = 5,
  parameter int CLEAR_T  = 1,
  parameter bit ACT_LOW  = 1'b1,
  parameter int PW = (PHASES < 2) ? 1 : $clog2(PHASES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic [PHASES-1:0] req_i,
  input  logic              flash_mode_i,
  output logic [PHASES-1:0] red_o,
  output logic [PHASES-1:0] yellow_o,
  output logic [PHASES-1:0] green_o,
  output logic [PW-1:0]     phase_o,
  output logic              flashing_o
);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_GREEN,
    ST_YELLOW,
    ST_FLASH
  } state_e;

  localparam logic [PHASES-1:0] POL = {PHASES{ACT_LOW}};

  state_e            state_q, state_d;
  logic [PW-1:0]     p_q, p_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PHASES-1:0] dem_q, dem_d;
  logic              fon_q, fon_d;

  logic [PHASES-1:0] red_q, red_d;
  logic [PHASES-1:0] yel_q, yel_d;
  logic [PHASES-1:0] grn_q, grn_d;
  logic              flash_q;

  logic [CNT_W-1:0]  dur;
  logic              expire;
  logic [PW-1:0]     nxt_p;
  logic [PHASES-1:0] grn_mask;
  logic [PHASES-1:0] lamp_sel;

  // First demanded phase after cur (cur itself last); cur+1 if none.
  function automatic logic [PW-1:0] pick_next(
    input logic [PW-1:0]     cur,
    input logic [PHASES-1:0] d
  );
    logic [PHASES-1:0] rot;
    logic [PW:0]       s;
    int                sel;
    rot = PHASES'({d, d} >> ({1'b0, cur} + (PW+1)'(1)));
    sel = 0;
    for (int k = PHASES - 1; k >= 0; k--) begin
      if (rot[k]) sel = k;
    end
    s = {1'b0, cur} + (PW+1)'(1) + (PW+1)'(sel);
    if (s >= (PW+1)'(PHASES)) s = s - (PW+1)'(PHASES);
    return s[PW-1:0];
  endfunction

  always_comb begin
    unique case (state_q)
      ST_GREEN:  dur = CNT_W'(GREEN_T);
      ST_YELLOW: dur = CNT_W'(YELLOW_T);
      ST_CLEAR:  dur = CNT_W'(CLEAR_T);
      ST_FLASH:  dur = CNT_W'(CLEAR_T);
    endcase
  end

  assign expire   = tick_i && (cnt_q == dur - CNT_W'(1));
  assign nxt_p    = pick_next(p_q, dem_q);
  assign grn_mask = (state_q == ST_GREEN) ? (PHASES'(1) << p_q) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      p_q     <= PW'(PHASES - 1);
      cnt_q   <= '0;
      dem_q   <= '0;
      fon_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      dem_q   <= dem_d;
      fon_q   <= fon_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    fon_d   = fon_q;
    dem_d   = dem_q | (req_i & ~grn_mask);
    if (tick_i) cnt_d = expire ? '0 : cnt_q + CNT_W'(1);
    unique case (state_q)
      ST_CLEAR: begin
        if (expire) begin
          if (flash_mode_i) begin
            state_d = ST_FLASH;
            fon_d   = 1'b1;
          end else begin
            state_d = ST_GREEN;
            p_d     = nxt_p;
            dem_d   = dem_d & ~(PHASES'(1) << nxt_p);
          end
        end
      end
      ST_GREEN: begin
        // Night mode cuts green short without waiting for a tick.
        if (flash_mode_i) begin
          state_d = ST_YELLOW;
          cnt_d   = '0;
        end else if (expire) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (expire) state_d = ST_CLEAR;
      end
      ST_FLASH: begin
        cnt_d = '0;
        if (!flash_mode_i) state_d = ST_CLEAR;
        else if (tick_i) fon_d = ~fon_q;
      end
    endcase
  end

  always_comb begin
    lamp_sel = PHASES'(1) << p_d;
    red_d    = '1;
    yel_d    = '0;
    grn_d    = '0;
    unique case (state_d)
      ST_CLEAR: ;
      ST_GREEN: begin
        grn_d = lamp_sel;
        red_d = ~lamp_sel;
      end
      ST_YELLOW: begin
        yel_d = lamp_sel;
        red_d = ~lamp_sel;
      end
      ST_FLASH: begin
        red_d = '0;
        yel_d = {PHASES{fon_d}};
      end
    endcase
  end

  // Lamps decode from next state so pins change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_q   <= ~POL;
      yel_q   <= POL;
      grn_q   <= POL;
      flash_q <= 1'b0;
    end else begin
      red_q   <= red_d ^ POL;
      yel_q   <= yel_d ^ POL;
      grn_q   <= grn_d ^ POL;
      flash_q <= (state_d == ST_FLASH);
    end
  end

  assign red_o      = red_q;
  assign yellow_o   = yel_q;
  assign green_o    = grn_q;
  assign phase_o    = p_q;
  assign flashing_o = flash_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi: two polarity variants checked every
// cycle against a countdown-based behavioural model.
module tb_traffic_ctrl_multi;

  localparam int NP = 3;
  localparam int GT = 4;
  localparam int YT = 2;
  localparam int CT = 1;
  localparam int PWT = 2;

  localparam int ALLRED = 0;
  localparam int GRN = 1;
  localparam int YEL = 2;
  localparam int FLS = 3;

  logic clk;
  logic rst;
  logic tick;
  logic fm;
  logic [NP-1:0] req;

  logic [NP-1:0] r_al, y_al, g_al;
  logic [NP-1:0] r_ah, y_ah, g_ah;
  logic [PWT-1:0] ph_al, ph_ah;
  logic f_al, f_ah;

  int n_chk;
  int n_pass;

  int m_s;
  int m_p;
  int m_left;
  int m_on;
  bit m_dem[NP];

  traffic_ctrl_multi #(
    .PHASES(NP), .CNT_W(8), .GREEN_T(GT),
    .YELLOW_T(YT), .CLEAR_T(CT), .ACT_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst(rst), .tick_i(tick), .req_i(req),
    .flash_mode_i(fm), .red_o(r_al), .yellow_o(y_al),
    .green_o(g_al), .phase_o(ph_al), .flashing_o(f_al)
  );

  traffic_ctrl_multi #(
    .PHASES(NP), .CNT_W(8), .GREEN_T(GT),
    .YELLOW_T(YT), .CLEAR_T(CT), .ACT_LOW(1'b0)
  ) dut_ah (
    .clk(clk), .rst(rst), .tick_i(tick), .req_i(req),
    .flash_mode_i(fm), .red_o(r_ah), .yellow_o(y_ah),
    .green_o(g_ah), .phase_o(ph_ah), .flashing_o(f_ah)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
  endtask

  task automatic model_reset();
    m_s = ALLRED;
    m_p = NP - 1;
    m_left = CT;
    m_on = 0;
    for (int i = 0; i < NP; i++) m_dem[i] = 1'b0;
  endtask

  task automatic model_step();
    bit nd[NP];
    int np;
    for (int i = 0; i < NP; i++)
      nd[i] = m_dem[i] | (req[i] && !(m_s == GRN && m_p == i));
    case (m_s)
      ALLRED: if (tick) begin
        m_left--;
        if (m_left == 0) begin
          if (fm) begin
            m_s = FLS;
            m_on = 1;
          end else begin
            np = (m_p + 1) % NP;
            for (int k = 1; k <= NP; k++) begin
              if (m_dem[(m_p + k) % NP]) begin
                np = (m_p + k) % NP;
                break;
              end
            end
            m_p = np;
            nd[np] = 1'b0;
            m_s = GRN;
            m_left = GT;
          end
        end
      end
      GRN: begin
        if (fm) begin
          m_s = YEL;
          m_left = YT;
        end else if (tick) begin
          m_left--;
          if (m_left == 0) begin
            m_s = YEL;
            m_left = YT;
          end
        end
      end
      YEL: if (tick) begin
        m_left--;
        if (m_left == 0) begin
          m_s = ALLRED;
          m_left = CT;
        end
      end
      default: begin
        if (!fm) begin
          m_s = ALLRED;
          m_left = CT;
        end else if (tick) begin
          m_on = 1 - m_on;
        end
      end
    endcase
    m_dem = nd;
  endtask

  task automatic check_outs();
    logic [NP-1:0] er, ey, eg, nr, ny, ng;
    er = '0;
    ey = '0;
    eg = '0;
    for (int i = 0; i < NP; i++) begin
      if (m_s == FLS) ey[i] = (m_on != 0);
      else if (m_s == GRN && m_p == i) eg[i] = 1'b1;
      else if (m_s == YEL && m_p == i) ey[i] = 1'b1;
      else er[i] = 1'b1;
    end
    nr = ~er;
    ny = ~ey;
    ng = ~eg;
    chk("red_ah", r_ah, er);
    chk("yel_ah", y_ah, ey);
    chk("grn_ah", g_ah, eg);
    chk("red_al", r_al, nr);
    chk("yel_al", y_al, ny);
    chk("grn_al", g_al, ng);
    chk("phase_ah", ph_ah, m_p);
    chk("phase_al", ph_al, m_p);
    chk("flash_ah", f_ah, m_s == FLS);
    chk("flash_al", f_al, m_s == FLS);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outs();
  endtask

  task automatic wait_green0_rise();
    int k;
    k = 0;
    while (g_ah[0] !== 1'b0 && k < 40) begin step(); k++; end
    k = 0;
    while (g_ah[0] !== 1'b1 && k < 40) begin step(); k++; end
    chk("wait_green0", g_ah[0], 1);
  endtask

  initial begin
    int k;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    tick = 1'b0;
    fm = 1'b0;
    req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    rst = 1'b0;

    // fixed-time rotation, tick every cycle
    tick = 1'b1;
    repeat (45) step();

    // one-cycle pulse on req[2] during phase 0 green
    wait_green0_rise();
    req = 3'b100;
    step();
    req = '0;
    repeat (20) step();

    // req[0] held through phase 0 green must not re-latch
    wait_green0_rise();
    k = 0;
    while (g_ah[0] === 1'b1 && k < 20) begin
      req = 3'b001;
      step();
      k++;
    end
    req = '0;
    repeat (20) step();

    // flash entry at green cycle 2, then exit
    wait_green0_rise();
    step();
    fm = 1'b1;
    repeat (10) step();
    tick = 1'b0;
    repeat (3) step();
    tick = 1'b1;
    repeat (2) step();
    fm = 1'b0;
    repeat (15) step();

    // slow timebase: tick every third cycle
    for (int c = 0; c < 90; c++) begin
      tick = (c % 3 == 0);
      step();
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick = ($urandom_range(0, 2) != 0);
      req = ($urandom_range(0, 5) == 0) ? NP'($urandom) : '0;
      if ($urandom_range(0, 59) == 0) fm = ~fm;
      step();
    end

    // asynchronous reset mid-yellow
    fm = 1'b0;
    req = '0;
    tick = 1'b1;
    repeat (10) step();
    k = 0;
    while ((y_ah == '0 || f_ah) && k < 40) begin step(); k++; end
    chk("wait_yel", (y_ah != '0) && !f_ah, 1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    #2;
    rst = 1'b0;
    repeat (25) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
